pwm_gen: RTL and testbench



---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_gen_if.sv | 13 +
 rtl/pwm_muldiv.sv | 56 +++++
 rtl/pwm_gen.sv | 133 +++++++++++++
 tb/tb_pwm_gen.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and FSM state encoding for the PWM generator.
package pwm_pkg;
    localparam int CNT_W      = 32;
    localparam int DUTY_SCALE = 1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        PEND = 2'd2
    } pwm_state_e;
endpackage

// File: rtl/pwm_gen_if.sv
// Configuration handshake bundle between a host and the PWM generator.
interface pwm_gen_if #(parameter int W = pwm_pkg::CNT_W);
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_duty;
    logic         cfg_err;

    modport master (output cfg_valid, cfg_period, cfg_duty,
                    input  cfg_ready, cfg_err);
    modport slave  (input  cfg_valid, cfg_period, cfg_duty,
                    output cfg_ready, cfg_err);
endinterface

// File: rtl/pwm_muldiv.sv
// Computes floor(period*duty/SCALE) with a restoring divide, one quotient bit per cycle.
module pwm_muldiv
    import pwm_pkg::*;
#(
    parameter int W     = CNT_W,
    parameter int SCALE = DUTY_SCALE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] period,
    input  logic [W-1:0] duty,
    output logic         done,
    output logic [W-1:0] quot
);
    localparam int IW = $clog2(2 * W);
    localparam logic [IW-1:0] LAST = IW'(2 * W - 1);

    logic [2*W-1:0] dvd;
    logic [W-1:0]   rem;
    logic [IW-1:0]  iter;
    logic           busy;
    logic [W:0]     rem_sh;
    logic [W:0]     rem_diff;
    logic           ge;

    assign rem_sh   = {rem, dvd[2*W-1]};
    assign rem_diff = rem_sh - (W+1)'(SCALE);
    assign ge       = rem_sh >= (W+1)'(SCALE);

    // The dividend register doubles as the quotient register: quotient bits
    // shift in at the bottom as dividend bits leave at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd  <= '0;
            rem  <= '0;
            iter <= '0;
            busy <= 1'b0;
        end else if (start) begin
            dvd  <= {{W{1'b0}}, period} * {{W{1'b0}}, duty};
            rem  <= '0;
            iter <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            rem  <= ge ? rem_diff[W-1:0] : rem_sh[W-1:0];
            dvd  <= {dvd[2*W-2:0], ge};
            iter <= iter + IW'(1);
            if (iter == LAST)
                busy <= 1'b0;
        end
    end

    // done marks the final iteration; quot holds the result from the next cycle on
    assign done = busy && (iter == LAST);
    assign quot = dvd[W-1:0];
endmodule

// File: rtl/pwm_gen.sv
// Programmable PWM generator with glitch-free, period-boundary configuration updates.
//
// state | meaning
// IDLE  | ready for a configuration
// CALC  | high-time divide in progress
// PEND  | result waiting for a period boundary (or applied at once when idle)
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W      = pwm_pkg::CNT_W,
    parameter int DUTY_SCALE = pwm_pkg::DUTY_SCALE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    pwm_gen_if.slave         cfg,
    output logic             pwm_out,
    output logic             period_start,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time
);
    pwm_state_e       state;
    logic             ready_q;
    logic             err_q;
    logic [CNT_W-1:0] pend_p;
    logic [CNT_W-1:0] act_p;
    logic [CNT_W-1:0] act_hi;
    logic [CNT_W-1:0] cnt;
    logic             run_q;

    logic [CNT_W-1:0] duty_c;
    logic             accept;
    logic             cfg_ok;
    logic             md_start;
    logic             md_done;
    logic [CNT_W-1:0] md_quot;
    logic             wrap;
    logic             load;
    logic [CNT_W-1:0] act_p_nxt;
    logic [CNT_W-1:0] act_hi_nxt;
    logic             run_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    assign duty_c   = (cfg.cfg_duty > CNT_W'(DUTY_SCALE)) ? CNT_W'(DUTY_SCALE) : cfg.cfg_duty;
    assign accept   = cfg.cfg_valid && ready_q;
    assign cfg_ok   = cfg.cfg_period >= CNT_W'(2);
    assign md_start = accept && cfg_ok;

    pwm_muldiv #(.W(CNT_W), .SCALE(DUTY_SCALE)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .period (cfg.cfg_period),
        .duty   (duty_c),
        .done   (md_done),
        .quot   (md_quot)
    );

    // run_q means the current cycle is part of a running period at position cnt
    assign wrap       = run_q && (cnt == act_p - CNT_W'(1));
    assign load       = (state == PEND) && (!run_q || wrap);
    assign act_p_nxt  = load ? pend_p : act_p;
    assign act_hi_nxt = load ? md_quot : act_hi;
    assign run_nxt    = enable && (act_p_nxt != '0);

    always_comb begin
        cnt_nxt = '0;
        if (run_nxt && run_q && !wrap)
            cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            pend_p  <= '0;
        end else begin
            err_q <= accept && !cfg_ok;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (md_start) begin
                        state   <= CALC;
                        ready_q <= 1'b0;
                        pend_p  <= cfg.cfg_period;
                    end
                end
                CALC: begin
                    if (md_done)
                        state <= PEND;
                end
                PEND: begin
                    if (load) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_p        <= '0;
            act_hi       <= '0;
            cnt          <= '0;
            run_q        <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            high_time    <= '0;
            low_time     <= '0;
        end else begin
            act_p        <= act_p_nxt;
            act_hi       <= act_hi_nxt;
            cnt          <= cnt_nxt;
            run_q        <= run_nxt;
            pwm_out      <= run_nxt && (cnt_nxt < act_hi_nxt);
            period_start <= run_nxt && (cnt_nxt == '0);
            if (load) begin
                high_time <= md_quot;
                low_time  <= pend_p - md_quot;
            end
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;
endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen with hand-computed expected waveforms and immediate assertions.
module tb_pwm_gen;
    import pwm_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             pwm_out;
    logic             period_start;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] low_time;

    int n_cmp;
    int n_err;
    int n;
    int pos;

    pwm_gen_if #(.W(CNT_W)) cfg ();

    pwm_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg          (cfg.slave),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .high_time    (high_time),
        .low_time     (low_time)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one request; the handshake edge passes inside this task.
    task automatic do_cfg(input int p, input int d);
        cfg.cfg_valid  = 1'b1;
        cfg.cfg_period = CNT_W'(p);
        cfg.cfg_duty   = CNT_W'(d);
        step();
        cfg.cfg_valid  = 1'b0;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!cfg.cfg_ready && cycles < 300) begin
            step();
            cycles++;
        end
        if (cycles >= 300)
            chk("ready_timeout", 32'(cycles), 32'd0);
    endtask

    // Starts on a period_start cycle and checks whole periods
    task automatic check_wave(input int p, input int hi, input int nper);
        for (int i = 0; i < nper * p; i++) begin
            chk("wave_pwm", 32'(pwm_out), 32'((i % p) < hi));
            chk("wave_ps",  32'(period_start), 32'((i % p) == 0));
            step();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_period = '0;
        cfg.cfg_duty = '0;
        repeat (3) step();

        chk("rst_pwm",   32'(pwm_out), 32'd0);
        chk("rst_ps",    32'(period_start), 32'd0);
        chk("rst_hi",    high_time, 32'd0);
        chk("rst_lo",    low_time, 32'd0);
        chk("rst_ready", 32'(cfg.cfg_ready), 32'd0);
        chk("rst_err",   32'(cfg.cfg_err), 32'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(cfg.cfg_ready), 32'd1);

        // nominal 10 / 300 -> 3 high, 7 low
        enable = 1'b1;
        do_cfg(10, 300);
        chk("ready_low_calc", 32'(cfg.cfg_ready), 32'd0);
        wait_ready(n);
        chk("first_latency", 32'(n), 32'd65);
        chk("nom_ps_at_apply", 32'(period_start), 32'd1);
        chk("nom_hi", high_time, 32'd3);
        chk("nom_lo", low_time, 32'd7);
        check_wave(10, 3, 2);

        // rounding: 7 * 500 / 1000 = 3.5 -> 3
        do_cfg(7, 500);
        wait_ready(n);
        chk("rnd_hi", high_time, 32'd3);
        chk("rnd_lo", low_time, 32'd4);
        check_wave(7, 3, 2);

        do_cfg(7, 0);
        wait_ready(n);
        chk("d0_hi", high_time, 32'd0);
        chk("d0_lo", low_time, 32'd7);
        check_wave(7, 0, 2);

        do_cfg(7, 1000);
        wait_ready(n);
        chk("d1000_hi", high_time, 32'd7);
        chk("d1000_lo", low_time, 32'd0);
        check_wave(7, 7, 2);

        // clamp
        do_cfg(8, 1500);
        chk("clamp_no_err", 32'(cfg.cfg_err), 32'd0);
        wait_ready(n);
        chk("clamp_hi", high_time, 32'd8);
        chk("clamp_lo", low_time, 32'd0);
        check_wave(8, 8, 1);

        // reject period < 2
        do_cfg(1, 500);
        chk("rej_err_pulse", 32'(cfg.cfg_err), 32'd1);
        chk("rej_ready", 32'(cfg.cfg_ready), 32'd1);
        step();
        chk("rej_err_clear", 32'(cfg.cfg_err), 32'd0);
        chk("rej_hi_kept", high_time, 32'd8);
        chk("rej_lo_kept", low_time, 32'd0);
        chk("rej_ready2", 32'(cfg.cfg_ready), 32'd1);

        // glitch-free update mid-period
        do_cfg(20, 250);
        wait_ready(n);
        chk("g_hi_old", high_time, 32'd5);
        chk("g_ps_old", 32'(period_start), 32'd1);
        repeat (3) step();
        pos = 3;
        do_cfg(10, 500);
        pos = 4;
        n = 0;
        while (!cfg.cfg_ready && n < 300) begin
            chk("g_old_pwm", 32'(pwm_out), 32'(pos < 5));
            chk("g_old_ps",  32'(period_start), 32'(pos == 0));
            step();
            pos = (pos + 1) % 20;
            n++;
        end
        chk("g_apply_at_wrap", 32'(pos), 32'd0);
        chk("g_ps_new", 32'(period_start), 32'd1);
        chk("g_hi_new", high_time, 32'd5);
        chk("g_lo_new", low_time, 32'd5);
        check_wave(10, 5, 2);

        // enable toggle mid-high
        repeat (2) step();
        chk("en_pwm_high", 32'(pwm_out), 32'd1);
        enable = 1'b0;
        step();
        chk("en_off_pwm", 32'(pwm_out), 32'd0);
        chk("en_off_ps", 32'(period_start), 32'd0);
        repeat (3) step();
        chk("en_off_pwm2", 32'(pwm_out), 32'd0);
        chk("en_off_hi_kept", high_time, 32'd5);
        enable = 1'b1;
        step();
        check_wave(10, 5, 1);

        // reset during CALC
        do_cfg(20, 100);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pwm", 32'(pwm_out), 32'd0);
        chk("mid_rst_ps", 32'(period_start), 32'd0);
        chk("mid_rst_hi", high_time, 32'd0);
        chk("mid_rst_lo", low_time, 32'd0);
        chk("mid_rst_ready", 32'(cfg.cfg_ready), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(cfg.cfg_ready), 32'd1);
        chk("post_rst_pwm", 32'(pwm_out), 32'd0);
        do_cfg(4, 500);
        wait_ready(n);
        chk("post_rst_latency", 32'(n), 32'd65);
        chk("post_rst_hi", high_time, 32'd2);
        chk("post_rst_lo", low_time, 32'd2);
        check_wave(4, 2, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
